// File: rtl/pcie_axi_dma_desc_tracker.sv
// pcie_axi_dma_desc_tracker: swaps wide client tags for narrow in-flight slot tags and restores them on status return.
module pcie_axi_dma_desc_tracker #(
   parameter int PCIE_ADDR_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH  = 16,
   parameter int LEN_WIDTH       = 20,
   parameter int USER_TAG_WIDTH  = 16,
   parameter int TAG_WIDTH       = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [PCIE_ADDR_WIDTH-1:0] s_axis_desc_pcie_addr,
   input  logic [AXI_ADDR_WIDTH-1:0]  s_axis_desc_axi_addr,
   input  logic [LEN_WIDTH-1:0]       s_axis_desc_len,
   input  logic [USER_TAG_WIDTH-1:0]  s_axis_desc_tag,
   input  logic                       s_axis_desc_valid,
   output logic                       s_axis_desc_ready,
   output logic [PCIE_ADDR_WIDTH-1:0] m_axis_desc_pcie_addr,
   output logic [AXI_ADDR_WIDTH-1:0]  m_axis_desc_axi_addr,
   output logic [LEN_WIDTH-1:0]       m_axis_desc_len,
   output logic [TAG_WIDTH-1:0]       m_axis_desc_tag,
   output logic                       m_axis_desc_valid,
   input  logic                       m_axis_desc_ready,
   input  logic [TAG_WIDTH-1:0]       s_axis_desc_status_tag,
   input  logic [3:0]                 s_axis_desc_status_error,
   input  logic                       s_axis_desc_status_valid,
   output logic [USER_TAG_WIDTH-1:0]  m_axis_desc_status_tag,
   output logic [3:0]                 m_axis_desc_status_error,
   output logic                       m_axis_desc_status_valid,
   output logic [TAG_WIDTH:0]         inflight_count,
   output logic                       stat_unexpected
);
   localparam int SLOTS = 2**TAG_WIDTH;
   logic [SLOTS-1:0]           active_q, active_d;
   logic [USER_TAG_WIDTH-1:0]  utag_q [SLOTS];
   logic [USER_TAG_WIDTH-1:0]  utag_d [SLOTS];
   logic [PCIE_ADDR_WIDTH-1:0] pcie_q, pcie_d;
   logic [AXI_ADDR_WIDTH-1:0]  axi_q, axi_d;
   logic [LEN_WIDTH-1:0]       len_q, len_d;
   logic [TAG_WIDTH-1:0]       mtag_q, mtag_d;
   logic                       mvalid_q, mvalid_d;
   logic [USER_TAG_WIDTH-1:0]  stag_q, stag_d;
   logic [3:0]                 serr_q, serr_d;
   logic                       svalid_q, svalid_d;
   logic [TAG_WIDTH:0]         count_q, count_d;
   logic                       unexp_q, unexp_d;
   logic [TAG_WIDTH-1:0]       free_idx;
   logic                       s_hs, st_hit;
   // Lowest inactive slot; only meaningful while at least one slot is free.
   always_comb begin
      free_idx = '0;
      for (int i = SLOTS-1; i >= 0; i--)
         if (!active_q[i]) free_idx = TAG_WIDTH'(i);
   end
   assign s_axis_desc_ready = ~&active_q && (!mvalid_q || m_axis_desc_ready);
   assign s_hs = s_axis_desc_valid && s_axis_desc_ready;
   assign st_hit = s_axis_desc_status_valid && active_q[s_axis_desc_status_tag];
   always_comb begin
      active_d = active_q;
      utag_d = utag_q;
      if (st_hit) active_d[s_axis_desc_status_tag] = 1'b0;
      if (s_hs) begin
         active_d[free_idx] = 1'b1;
         utag_d[free_idx] = s_axis_desc_tag;
      end
      pcie_d = s_hs ? s_axis_desc_pcie_addr : pcie_q;
      axi_d = s_hs ? s_axis_desc_axi_addr : axi_q;
      len_d = s_hs ? s_axis_desc_len : len_q;
      mtag_d = s_hs ? free_idx : mtag_q;
      mvalid_d = s_hs || (mvalid_q && !m_axis_desc_ready);
      stag_d = st_hit ? utag_q[s_axis_desc_status_tag] : stag_q;
      serr_d = st_hit ? s_axis_desc_status_error : serr_q;
      svalid_d = st_hit;
      count_d = count_q + (TAG_WIDTH+1)'(s_hs) - (TAG_WIDTH+1)'(st_hit);
      unexp_d = s_axis_desc_status_valid && !active_q[s_axis_desc_status_tag];
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q <= '0;
         utag_q <= '{default: '0};
         pcie_q <= '0;
         axi_q <= '0;
         len_q <= '0;
         mtag_q <= '0;
         mvalid_q <= 1'b0;
         stag_q <= '0;
         serr_q <= '0;
         svalid_q <= 1'b0;
         count_q <= '0;
         unexp_q <= 1'b0;
      end else begin
         active_q <= active_d;
         utag_q <= utag_d;
         pcie_q <= pcie_d;
         axi_q <= axi_d;
         len_q <= len_d;
         mtag_q <= mtag_d;
         mvalid_q <= mvalid_d;
         stag_q <= stag_d;
         serr_q <= serr_d;
         svalid_q <= svalid_d;
         count_q <= count_d;
         unexp_q <= unexp_d;
      end
   end
   assign m_axis_desc_pcie_addr = pcie_q;
   assign m_axis_desc_axi_addr = axi_q;
   assign m_axis_desc_len = len_q;
   assign m_axis_desc_tag = mtag_q;
   assign m_axis_desc_valid = mvalid_q;
   assign m_axis_desc_status_tag = stag_q;
   assign m_axis_desc_status_error = serr_q;
   assign m_axis_desc_status_valid = svalid_q;
   assign inflight_count = count_q;
   assign stat_unexpected = unexp_q;
endmodule

// File: tb/tb_pcie_axi_dma_desc_tracker.sv
// tb_pcie_axi_dma_desc_tracker: directed scenario tasks with hand-computed expectations.
module tb_pcie_axi_dma_desc_tracker;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] s_pcie;
   logic [15:0] s_axi;
   logic [19:0] s_len;
   logic [15:0] s_tag;
   logic        s_valid, s_ready;
   logic [63:0] m_pcie;
   logic [15:0] m_axi;
   logic [19:0] m_len;
   logic [3:0]  m_tag;
   logic        m_valid, m_ready;
   logic [3:0]  st_tag;
   logic [3:0]  st_err;
   logic        st_valid;
   logic [15:0] so_tag;
   logic [3:0]  so_err;
   logic        so_valid;
   logic [4:0]  count;
   logic        unexp;
   int pass_cnt = 0;
   int total_cnt = 0;
   always #5 clk = ~clk;
   pcie_axi_dma_desc_tracker dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_desc_pcie_addr(s_pcie), .s_axis_desc_axi_addr(s_axi),
      .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
      .s_axis_desc_valid(s_valid), .s_axis_desc_ready(s_ready),
      .m_axis_desc_pcie_addr(m_pcie), .m_axis_desc_axi_addr(m_axi),
      .m_axis_desc_len(m_len), .m_axis_desc_tag(m_tag),
      .m_axis_desc_valid(m_valid), .m_axis_desc_ready(m_ready),
      .s_axis_desc_status_tag(st_tag), .s_axis_desc_status_error(st_err),
      .s_axis_desc_status_valid(st_valid),
      .m_axis_desc_status_tag(so_tag), .m_axis_desc_status_error(so_err),
      .m_axis_desc_status_valid(so_valid),
      .inflight_count(count), .stat_unexpected(unexp)
   );
   task automatic set_desc(input logic [15:0] tag, input logic [19:0] len);
      s_valid = 1'b1;
      s_tag = tag;
      s_len = len;
      s_axi = tag;
      s_pcie = 64'hA000_0000_0000_0000 | {48'h0, tag};
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic reset_dut();
      rst_n = 1'b0;
      s_valid = 1'b0;
      st_valid = 1'b0;
      m_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      #1;
   endtask
   task automatic test_reset();
      reset_dut();
      total_cnt++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
      total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b exp 0", m_valid); else pass_cnt++;
      total_cnt++; if (so_valid !== 1'b0) $display("FAIL reset_status_valid got %b exp 0", so_valid); else pass_cnt++;
      total_cnt++; if (unexp !== 1'b0) $display("FAIL reset_unexp got %b exp 0", unexp); else pass_cnt++;
      total_cnt++; if (m_len !== 20'h0 || m_tag !== 4'h0 || so_tag !== 16'h0) $display("FAIL reset_data got len %h tag %h stag %h exp 0", m_len, m_tag, so_tag); else pass_cnt++;
      total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b exp 1", s_ready); else pass_cnt++;
   endtask
   task automatic test_single();
      reset_dut();
      set_desc(16'hBEEF, 20'h100);
      tick();
      s_valid = 1'b0;
      total_cnt++; if (m_valid !== 1'b1 || m_tag !== 4'd0) $display("FAIL single_desc got valid %b tag %0d exp 1 0", m_valid, m_tag); else pass_cnt++;
      total_cnt++; if (m_len !== 20'h100 || m_pcie !== 64'hA000_0000_0000_BEEF) $display("FAIL single_fields got len %h pcie %h exp 100 a00000000000beef", m_len, m_pcie); else pass_cnt++;
      total_cnt++; if (count !== 5'd1) $display("FAIL single_count1 got %0d exp 1", count); else pass_cnt++;
      st_valid = 1'b1; st_tag = 4'd0; st_err = 4'd0;
      tick();
      st_valid = 1'b0;
      total_cnt++; if (so_valid !== 1'b1 || so_tag !== 16'hBEEF || so_err !== 4'd0) $display("FAIL single_status got v %b tag %h err %h exp 1 beef 0", so_valid, so_tag, so_err); else pass_cnt++;
      total_cnt++; if (count !== 5'd0 || m_valid !== 1'b0) $display("FAIL single_count0 got count %0d mvalid %b exp 0 0", count, m_valid); else pass_cnt++;
      tick();
      total_cnt++; if (so_valid !== 1'b0) $display("FAIL single_status_pulse got %b exp 0", so_valid); else pass_cnt++;
   endtask
   task automatic test_fill();
      int bad = 0;
      reset_dut();
      for (int i = 0; i < 16; i++) begin
         set_desc(16'h100 + 16'(i), 20'(i));
         tick();
         if (m_tag !== 4'(i) || m_valid !== 1'b1) bad++;
      end
      s_valid = 1'b0;
      total_cnt++; if (bad != 0) $display("FAIL fill_tags got %0d bad slots exp 0", bad); else pass_cnt++;
      total_cnt++; if (count !== 5'd16) $display("FAIL fill_count got %0d exp 16", count); else pass_cnt++;
      total_cnt++; if (s_ready !== 1'b0) $display("FAIL fill_s_ready got %b exp 0", s_ready); else pass_cnt++;
      set_desc(16'h555, 20'h55);
      st_valid = 1'b1; st_tag = 4'd5; st_err = 4'd0;
      #1;
      total_cnt++; if (s_ready !== 1'b0) $display("FAIL fill_same_cycle_ready got %b exp 0", s_ready); else pass_cnt++;
      tick();
      st_valid = 1'b0;
      total_cnt++; if (so_valid !== 1'b1 || so_tag !== 16'h105) $display("FAIL fill_status got v %b tag %h exp 1 105", so_valid, so_tag); else pass_cnt++;
      total_cnt++; if (count !== 5'd15 || s_ready !== 1'b1) $display("FAIL fill_after_free got count %0d ready %b exp 15 1", count, s_ready); else pass_cnt++;
      tick();
      s_valid = 1'b0;
      total_cnt++; if (m_tag !== 4'd5 || m_valid !== 1'b1 || m_len !== 20'h55 || count !== 5'd16) $display("FAIL fill_realloc got tag %0d v %b len %h count %0d exp 5 1 55 16", m_tag, m_valid, m_len, count); else pass_cnt++;
   endtask
   task automatic test_backpressure();
      int bad = 0;
      reset_dut();
      m_ready = 1'b0;
      set_desc(16'h11, 20'h11);
      tick();
      set_desc(16'h22, 20'h22);
      for (int i = 0; i < 4; i++) begin
         if (m_valid !== 1'b1 || m_tag !== 4'd0 || m_len !== 20'h11 || m_axi !== 16'h11 || m_pcie !== 64'hA000_0000_0000_0011 || s_ready !== 1'b0 || count !== 5'd1) bad++;
         tick();
      end
      total_cnt++; if (bad != 0) $display("FAIL bp_stable got %0d bad cycles exp 0", bad); else pass_cnt++;
      m_ready = 1'b1;
      #1;
      total_cnt++; if (s_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", s_ready); else pass_cnt++;
      tick();
      total_cnt++; if (m_tag !== 4'd1 || m_len !== 20'h22 || count !== 5'd2) $display("FAIL bp_resume1 got tag %0d len %h count %0d exp 1 22 2", m_tag, m_len, count); else pass_cnt++;
      set_desc(16'h33, 20'h33);
      tick();
      s_valid = 1'b0;
      total_cnt++; if (m_tag !== 4'd2 || m_len !== 20'h33 || count !== 5'd3) $display("FAIL bp_resume2 got tag %0d len %h count %0d exp 2 33 3", m_tag, m_len, count); else pass_cnt++;
      tick();
      total_cnt++; if (m_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", m_valid); else pass_cnt++;
   endtask
   task automatic test_out_of_order();
      reset_dut();
      set_desc(16'hA, 20'h1); tick();
      set_desc(16'hB, 20'h2); tick();
      set_desc(16'hC, 20'h3); tick();
      s_valid = 1'b0;
      st_valid = 1'b1; st_tag = 4'd2; st_err = 4'd0;
      tick();
      total_cnt++; if (so_valid !== 1'b1 || so_tag !== 16'hC || so_err !== 4'd0) $display("FAIL ooo_first got v %b tag %h err %h exp 1 c 0", so_valid, so_tag, so_err); else pass_cnt++;
      st_tag = 4'd0; st_err = 4'd3;
      tick();
      total_cnt++; if (so_valid !== 1'b1 || so_tag !== 16'hA || so_err !== 4'd3) $display("FAIL ooo_second got v %b tag %h err %h exp 1 a 3", so_valid, so_tag, so_err); else pass_cnt++;
      st_tag = 4'd1; st_err = 4'd0;
      tick();
      st_valid = 1'b0;
      total_cnt++; if (so_valid !== 1'b1 || so_tag !== 16'hB || so_err !== 4'd0) $display("FAIL ooo_third got v %b tag %h err %h exp 1 b 0", so_valid, so_tag, so_err); else pass_cnt++;
      total_cnt++; if (count !== 5'd0) $display("FAIL ooo_count got %0d exp 0", count); else pass_cnt++;
   endtask
   task automatic test_simultaneous();
      reset_dut();
      set_desc(16'h70, 20'h0); tick();
      set_desc(16'h71, 20'h0); tick();
      set_desc(16'h72, 20'h0); tick();
      set_desc(16'h77, 20'h7);
      st_valid = 1'b1; st_tag = 4'd1; st_err = 4'd0;
      tick();
      s_valid = 1'b0;
      st_tag = 4'd9;
      total_cnt++; if (count !== 5'd3) $display("FAIL simul_count got %0d exp 3", count); else pass_cnt++;
      total_cnt++; if (m_tag !== 4'd3 || so_valid !== 1'b1 || so_tag !== 16'h71 || unexp !== 1'b0) $display("FAIL simul_alloc_free got mtag %0d sv %b stag %h unexp %b exp 3 1 71 0", m_tag, so_valid, so_tag, unexp); else pass_cnt++;
      tick();
      st_valid = 1'b0;
      total_cnt++; if (unexp !== 1'b1 || so_valid !== 1'b0 || count !== 5'd3) $display("FAIL simul_unexp got unexp %b sv %b count %0d exp 1 0 3", unexp, so_valid, count); else pass_cnt++;
      tick();
      total_cnt++; if (unexp !== 1'b0) $display("FAIL simul_unexp_pulse got %b exp 0", unexp); else pass_cnt++;
      set_desc(16'h88, 20'h8);
      st_valid = 1'b1; st_tag = 4'd1;
      tick();
      s_valid = 1'b0;
      st_valid = 1'b0;
      total_cnt++; if (unexp !== 1'b1 || m_tag !== 4'd1 || so_valid !== 1'b0 || count !== 5'd4) $display("FAIL simul_alloc_status got unexp %b mtag %0d sv %b count %0d exp 1 1 0 4", unexp, m_tag, so_valid, count); else pass_cnt++;
   endtask
   task automatic test_reset_mid();
      reset_dut();
      m_ready = 1'b0;
      set_desc(16'h1, 20'h0); m_ready = 1'b1; tick();
      set_desc(16'h2, 20'h0); tick();
      set_desc(16'h3, 20'h0); tick();
      set_desc(16'h4, 20'h0);
      m_ready = 1'b0;
      tick();
      s_valid = 1'b0;
      st_valid = 1'b1; st_tag = 4'd0; st_err = 4'd0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      st_valid = 1'b0;
      m_ready = 1'b1;
      #1;
      total_cnt++; if (count !== 5'd0 || m_valid !== 1'b0 || so_valid !== 1'b0 || unexp !== 1'b0) $display("FAIL mid_reset_state got count %0d mv %b sv %b ux %b exp 0 0 0 0", count, m_valid, so_valid, unexp); else pass_cnt++;
      total_cnt++; if (s_ready !== 1'b1) $display("FAIL mid_reset_ready got %b exp 1", s_ready); else pass_cnt++;
      set_desc(16'h99, 20'h9);
      tick();
      s_valid = 1'b0;
      total_cnt++; if (m_tag !== 4'd0 || count !== 5'd1) $display("FAIL mid_reset_realloc got tag %0d count %0d exp 0 1", m_tag, count); else pass_cnt++;
      st_valid = 1'b1; st_tag = 4'd2;
      tick();
      st_valid = 1'b0;
      total_cnt++; if (unexp !== 1'b1 || so_valid !== 1'b0) $display("FAIL mid_reset_late_status got unexp %b sv %b exp 1 0", unexp, so_valid); else pass_cnt++;
   endtask
   initial begin
      rst_n = 1'b0;
      s_valid = 1'b0; s_tag = '0; s_len = '0; s_axi = '0; s_pcie = '0;
      m_ready = 1'b1;
      st_valid = 1'b0; st_tag = '0; st_err = '0;
      repeat (2) @(posedge clk);
      test_reset();
      test_single();
      test_fill();
      test_backpressure();
      test_out_of_order();
      test_simultaneous();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
